button_conditioner: RTL and testbench

//  Front end for the 7 note push-buttons. Synchronises and debounces each raw input, then enforces one-hot.

---
 rtl/button_pkg.sv | 14 +
 rtl/debounce_bit.sv | 49 ++++
 rtl/button_conditioner.sv | 120 ++++++++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM encoding and default sizes for the button conditioner
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACTIVE       = 2'd1,
    WAIT_RELEASE = 2'd2
  } btn_state_t;

  localparam int N_BTN_DEFAULT           = 7;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 20;
  localparam int CNT_W_DEFAULT           = 5;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser, polarity fix and debounce filter for one key
module debounce_bit
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

  logic             sync1;
  logic             sync2;
  logic             pressed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= RAW_RELEASED;
      sync2 <= RAW_RELEASED;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // The counter only runs while the synced level disagrees, so it can never wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (pressed == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced one-hot key front end; BTN_MULTI_REJECT_EN rejects chords in IDLE
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] botoes,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             busy_lock,
  output logic [N_BTN-1:0] db_debounced
);

  logic [N_BTN-1:0] deb;
  logic [N_BTN-1:0] pick;
  logic [N_BTN-1:0] captured;
  logic [N_BTN-1:0] captured_next;
  logic [N_BTN-1:0] botoes_next;
  logic             press_next;
  logic             release_next;
  btn_state_t       state;
  btn_state_t       state_next;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(deb[i])
    );
  end

  assign db_debounced = deb;

  // Scan downwards so the lowest-index pressed key wins.
  always_comb begin
    pick = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (deb[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

`ifdef BTN_MULTI_REJECT_EN
  logic multi;
  assign multi = (deb & (deb - 1'b1)) != '0;
`endif

  always_comb begin
    state_next    = state;
    captured_next = captured;
    botoes_next   = '0;
    press_next    = 1'b0;
    release_next  = 1'b0;
    case (state)
      IDLE: begin
        if (deb != '0) begin
`ifdef BTN_MULTI_REJECT_EN
          if (multi) begin
            state_next = WAIT_RELEASE;
          end else begin
            captured_next = pick;
            botoes_next   = pick;
            press_next    = 1'b1;
            state_next    = ACTIVE;
          end
`else
          captured_next = pick;
          botoes_next   = pick;
          press_next    = 1'b1;
          state_next    = ACTIVE;
`endif
        end
      end
      ACTIVE: begin
        if ((deb & captured) == '0) begin
          release_next = 1'b1;
          state_next   = (deb == '0) ? IDLE : WAIT_RELEASE;
        end else begin
          botoes_next = captured;
        end
      end
      WAIT_RELEASE: begin
        if (deb == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      captured      <= '0;
      botoes        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      captured      <= captured_next;
      botoes        <= botoes_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  assign busy_lock = (state == WAIT_RELEASE);

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner against a behavioural model
module tb_button_conditioner;

  localparam int NB = 7;
  localparam int DB = 4;
`ifdef BTN_MULTI_REJECT_EN
  localparam bit REJECT = 1'b1;
`else
  localparam bit REJECT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '1;
  logic [NB-1:0] botoes;
  logic          press_pulse;
  logic          release_pulse;
  logic          busy_lock;
  logic [NB-1:0] db_debounced;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(3), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .botoes(botoes),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .busy_lock(busy_lock), .db_debounced(db_debounced)
  );

  always #5 clock = ~clock;

  typedef struct { logic [NB-1:0] bot; bit busy; logic [NB-1:0] db; } snap_t;
  typedef struct { int cyc; bit is_press; logic [NB-1:0] bot; bit busy; } ev_t;

  snap_t snap_q[$];
  ev_t   ev_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  // Model state: pressed-level delay line, per-key history window, accepted levels, held key, lock flag.
  logic [NB-1:0] sync_q[$];
  logic [DB-1:0] win[NB];
  logic [NB-1:0] m_deb;
  int            m_held;
  bit            m_locked;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lowest(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [NB-1:0] raw, input bit rst);
    logic [NB-1:0] d;
    logic [NB-1:0] p;
    bit pe = 1'b0;
    bit re = 1'b0;
    if (rst) begin
      sync_q = '{7'h00, 7'h00};
      for (int b = 0; b < NB; b++) win[b] = '0;
      m_deb = '0; m_held = -1; m_locked = 1'b0;
    end else begin
      d = m_deb;
      if (m_locked) begin
        if (d == '0) m_locked = 1'b0;
      end else if (m_held >= 0) begin
        if (!d[m_held]) begin re = 1'b1; m_held = -1; m_locked = (d != '0); end
      end else if (d != '0) begin
        if (REJECT && $countones(d) > 1) m_locked = 1'b1;
        else begin m_held = lowest(d); pe = 1'b1; end
      end
      p = sync_q.pop_front();
      sync_q.push_back(~raw);
      // A level is accepted once the last DB synced samples all disagree with it.
      for (int b = 0; b < NB; b++) begin
        win[b] = {win[b][DB-2:0], p[b]};
        if (win[b] == {DB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
      end
    end
    snap_q.push_back('{bot: (m_held >= 0) ? NB'(1) << m_held : '0, busy: m_locked, db: m_deb});
    if (pe || re)
      ev_q.push_back('{cyc: cyc, is_press: pe, bot: (m_held >= 0) ? NB'(1) << m_held : '0, busy: m_locked});
  endtask

  task automatic step(input logic [NB-1:0] raw, input bit rst);
    #1;
    btn_raw = raw;
    reset   = rst;
    @(posedge clock);
    cyc++;
    model_edge(raw, rst);
  endtask

  task automatic hold(input logic [NB-1:0] pressed, input int n);
    for (int i = 0; i < n; i++) step(~pressed, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [NB-1:0] bot, input bit pp, input bit rp, input bit bz);
    #2;
    check(botoes === bot,         {tag, "_botoes"},  32'(botoes),        32'(bot));
    check(press_pulse === pp,     {tag, "_press"},   32'(press_pulse),   32'(pp));
    check(release_pulse === rp,   {tag, "_release"}, 32'(release_pulse), 32'(rp));
    check(busy_lock === bz,       {tag, "_busy"},    32'(busy_lock),     32'(bz));
  endtask

  always @(negedge clock) begin
    snap_t s;
    ev_t   e;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      check(botoes === s.bot,        "botoes",       32'(botoes),       32'(s.bot));
      check(busy_lock === s.busy,    "busy_lock",    32'(busy_lock),    32'(s.busy));
      check(db_debounced === s.db,   "db_debounced", 32'(db_debounced), 32'(s.db));
      check(!(press_pulse && release_pulse), "pulse_exclusive", 32'({press_pulse, release_pulse}), 32'(0));
      if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        check(1'b0, "missing_pulse", 32'(cyc), 32'(ev_q[0].cyc));
        void'(ev_q.pop_front());
      end
      if (press_pulse || release_pulse) begin
        if (ev_q.size() == 0) begin
          check(1'b0, "spurious_pulse", 32'({press_pulse, release_pulse}), 32'(0));
        end else begin
          e = ev_q.pop_front();
          check(e.cyc == cyc,                 "pulse_cycle", 32'(cyc),         32'(e.cyc));
          check(press_pulse == e.is_press,    "pulse_kind",  32'(press_pulse), 32'(e.is_press));
          check(botoes === e.bot,             "pulse_bus",   32'(botoes),      32'(e.bot));
          check(busy_lock === e.busy,         "pulse_busy",  32'(busy_lock),   32'(e.busy));
        end
      end
    end
  end

  initial begin
    logic [NB-1:0] mask;
    int len;
    bit rst;

    // Reset with all keys up.
    for (int i = 0; i < 3; i++) step('1, 1'b1);
    expect_out("reset", '0, 1'b0, 1'b0, 1'b0);
    check(db_debounced === '0, "reset_db", 32'(db_debounced), 32'(0));
    hold('0, 3);

    // Clean press of key 2: accepted on the 7th edge, released 7 edges after release.
    hold(7'b0000100, 6);
    expect_out("p2_early", '0, 1'b0, 1'b0, 1'b0);
    hold(7'b0000100, 1);
    expect_out("p2_press", 7'b0000100, 1'b1, 1'b0, 1'b0);
    hold(7'b0000100, 1);
    expect_out("p2_hold", 7'b0000100, 1'b0, 1'b0, 1'b0);
    hold(7'b0000100, 4);
    hold('0, 7);
    expect_out("p2_release", '0, 1'b0, 1'b1, 1'b0);
    hold('0, 4);

    // Bounce on key 3 shorter than the filter.
    hold(7'b0001000, 3); hold('0, 2); hold(7'b0001000, 2);
    hold('0, 12);
    expect_out("bounce", '0, 1'b0, 1'b0, 1'b0);

    // Key 2 held, key 5 joins, key 2 released: lock until everything is up.
    hold(7'b0000100, 7);
    expect_out("k4_press", 7'b0000100, 1'b1, 1'b0, 1'b0);
    hold(7'b0100100, 8);
    expect_out("k4_other", 7'b0000100, 1'b0, 1'b0, 1'b0);
    hold(7'b0100000, 7);
    expect_out("k4_release", '0, 1'b0, 1'b1, 1'b1);
    hold(7'b0100000, 4);
    hold('0, 7);
    expect_out("k4_unlock", '0, 1'b0, 1'b0, 1'b0);
    hold('0, 4);

    // Chord of keys 1 and 4 from IDLE.
    hold(7'b0010010, 7);
    expect_out("chord", REJECT ? 7'b0000000 : 7'b0000010, !REJECT, 1'b0, REJECT);
    hold(7'b0010010, 4);
    hold('0, 12);

    // Reset while key 6 is accepted and held: fresh press after re-debounce.
    hold(7'b1000000, 9);
    step(~7'b1000000, 1'b1);
    expect_out("k6_reset", '0, 1'b0, 1'b0, 1'b0);
    hold(7'b1000000, 6);
    expect_out("k6_wait", '0, 1'b0, 1'b0, 1'b0);
    hold(7'b1000000, 1);
    expect_out("k6_repress", 7'b1000000, 1'b1, 1'b0, 1'b0);
    hold('0, 12);

    // Randomised segments: idle, single keys, chords, short bounces and occasional resets.
    for (int seg = 0; seg < 180; seg++) begin
      len = $urandom_range(1, 14);
      case ($urandom_range(0, 9))
        0, 1, 2:       mask = '0;
        3, 4, 5, 6:    mask = NB'(1) << $urandom_range(0, NB - 1);
        default:       mask = (NB'(1) << $urandom_range(0, NB - 1)) | (NB'(1) << $urandom_range(0, NB - 1));
      endcase
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < len; i++) step(~mask, rst && (i == 0));
    end
    hold('0, 20);

    @(negedge clock);
    #1;
    check(ev_q.size() == 0, "events_drained", 32'(ev_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
